// File: rtl/spi_tx_sequencer.sv
// spi_tx_sequencer: byte FIFO plus launch sequencer in front of an SPI master.
// One transfer per queued byte; received bytes come back as a one-cycle strobe.
module spi_tx_sequencer #(
    parameter int DEPTH          = 8,
    parameter int AW             = 3,
    parameter int GAP_CYCLES     = 2,
    parameter int LAUNCH_TIMEOUT = 15
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_wr_valid,
    input  logic [7:0]    i_wr_data,
    output logic          o_wr_ready,
    output logic [AW:0]   o_fifo_level,
    output logic          o_tx_enable,
    output logic [7:0]    o_data_tx,
    input  logic          i_tx_busy,
    input  logic [7:0]    i_data_rx,
    output logic          o_rx_valid,
    output logic [7:0]    o_rx_data,
    output logic          o_timeout_err,
    output logic          o_idle
);

    localparam int GAP_EFF = (GAP_CYCLES < 2) ? 2 : GAP_CYCLES;
    localparam int TW      = $clog2(LAUNCH_TIMEOUT + 1);
    localparam int GW      = $clog2(GAP_EFF + 1);

    localparam logic [TW-1:0] TO_LAST  = TW'(LAUNCH_TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_EFF - 1);
    localparam logic [AW:0]   FULL     = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_BUSY,
        S_CAPTURE,
        S_GAP
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          tx_en_q, tx_en_d;
    logic [7:0]    data_tx_q, data_tx_d;
    logic          rx_valid_q, rx_valid_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          tmo_q, tmo_d;
    logic          wr_ready_q, wr_ready_d;
    logic          idle_q, idle_d;
    logic          push;
    logic          pop;

    // Next-state for FIFO pointers, FSM, timers and all registered outputs.
    always_comb begin
        push       = i_wr_valid && wr_ready_q;
        pop        = (state_q == S_IDLE) && (level_q != '0);
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        tmr_d      = tmr_q;
        gap_d      = gap_q;
        data_tx_d  = data_tx_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        tmo_d      = 1'b0;

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({push, pop})
            2'b10:   level_d = level_q + (AW + 1)'(1);
            2'b01:   level_d = level_q - (AW + 1)'(1);
            default: level_d = level_q;
        endcase

        unique case (state_q)
            S_IDLE: begin
                if (pop) begin
                    data_tx_d = mem_q[rd_ptr_q];
                    tmr_d     = '0;
                    state_d   = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                tmr_d = tmr_q + TW'(1);
                if (i_tx_busy) begin
                    state_d = S_BUSY;
                end else if (tmr_q == TO_LAST) begin
                    tmo_d   = 1'b1;
                    gap_d   = '0;
                    state_d = S_GAP;
                end
            end
            S_BUSY: begin
                if (!i_tx_busy) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                rx_data_d  = i_data_rx;
                rx_valid_d = 1'b1;
                gap_d      = '0;
                state_d    = S_GAP;
            end
            S_GAP: begin
                gap_d = gap_q + GW'(1);
                if (gap_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Enable rises one cycle after LAUNCH entry so data is set up first,
        // and drops on the same edge that leaves LAUNCH.
        tx_en_d    = (state_q == S_LAUNCH) && (state_d == S_LAUNCH);
        wr_ready_d = (level_d < FULL);
        idle_d     = (state_d == S_IDLE) && (level_d == '0);
    end

    // FIFO storage; contents need no reset since level gates every read.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= i_wr_data;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            tmr_q      <= '0;
            gap_q      <= '0;
            tx_en_q    <= 1'b0;
            data_tx_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
            tmo_q      <= 1'b0;
            wr_ready_q <= 1'b1;
            idle_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            tmr_q      <= tmr_d;
            gap_q      <= gap_d;
            tx_en_q    <= tx_en_d;
            data_tx_q  <= data_tx_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
            tmo_q      <= tmo_d;
            wr_ready_q <= wr_ready_d;
            idle_q     <= idle_d;
        end
    end

    assign o_wr_ready    = wr_ready_q;
    assign o_fifo_level  = level_q;
    assign o_tx_enable   = tx_en_q;
    assign o_data_tx     = data_tx_q;
    assign o_rx_valid    = rx_valid_q;
    assign o_rx_data     = rx_data_q;
    assign o_timeout_err = tmo_q;
    assign o_idle        = idle_q;

endmodule

// File: tb/tb_spi_tx_sequencer.sv
// tb_spi_tx_sequencer: scoreboard bench with a simple SPI master model.
// Expected tx bytes are queued on write, expected rx bytes by the master.
module tb_spi_tx_sequencer;

    localparam int LAUNCH_TIMEOUT = 15;

    logic       clk;
    logic       rst_n;
    logic       i_wr_valid;
    logic [7:0] i_wr_data;
    logic       o_wr_ready;
    logic [3:0] o_fifo_level;
    logic       o_tx_enable;
    logic [7:0] o_data_tx;
    logic       i_tx_busy;
    logic [7:0] i_data_rx;
    logic       o_rx_valid;
    logic [7:0] o_rx_data;
    logic       o_timeout_err;
    logic       o_idle;

    spi_tx_sequencer #(
        .DEPTH(8),
        .AW(3),
        .GAP_CYCLES(2),
        .LAUNCH_TIMEOUT(LAUNCH_TIMEOUT)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_wr_valid(i_wr_valid),
        .i_wr_data(i_wr_data),
        .o_wr_ready(o_wr_ready),
        .o_fifo_level(o_fifo_level),
        .o_tx_enable(o_tx_enable),
        .o_data_tx(o_data_tx),
        .i_tx_busy(i_tx_busy),
        .i_data_rx(i_data_rx),
        .o_rx_valid(o_rx_valid),
        .o_rx_data(o_rx_data),
        .o_timeout_err(o_timeout_err),
        .o_idle(o_idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] exp_tx [$];
    logic [7:0] exp_rx [$];
    int         checks = 0;
    int         failures = 0;
    int         rx_cnt = 0;
    int         tmo_cnt = 0;
    int         rise_cnt = 0;
    int         low_run = 100;
    logic       en_prev_mon = 1'b0;
    logic [7:0] cur_tx = 8'h00;
    bit         master_never = 1'b0;
    bit         abort_req = 1'b0;
    logic [7:0] rx_next = 8'h3C;

    // Master model: busy 3 cycles after enable rises, held 9 cycles.
    initial begin
        logic m_prev;
        bit   aborted;
        m_prev = 1'b0;
        forever begin
            @(posedge clk);
            #3;
            if (!master_never && o_tx_enable && !m_prev) begin
                repeat (3) begin
                    @(posedge clk);
                    #3;
                end
                i_data_rx = rx_next;
                i_tx_busy = 1'b1;
                aborted = 1'b0;
                for (int k = 0; k < 9; k++) begin
                    @(posedge clk);
                    #3;
                    if (abort_req) begin
                        aborted = 1'b1;
                        break;
                    end
                end
                i_tx_busy = 1'b0;
                abort_req = 1'b0;
                if (!aborted) begin
                    exp_rx.push_back(rx_next);
                    rx_next = rx_next + 8'd1;
                end
            end
            m_prev = o_tx_enable;
        end
    end

    // Output monitor: launch order, gap, tx stability, rx scoreboard.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (o_tx_enable && !en_prev_mon) begin
                    rise_cnt++;
                    checks++;
                    if (exp_tx.size() == 0) begin
                        failures++;
                        $display("FAIL launch_unexpected data=%h", o_data_tx);
                    end else begin
                        e = exp_tx.pop_front();
                        cur_tx = e;
                        if (o_data_tx !== e) begin
                            failures++;
                            $display("FAIL launch_data got=%h exp=%h", o_data_tx, e);
                        end
                    end
                    checks++;
                    if (low_run < 2) begin
                        failures++;
                        $display("FAIL enable_gap got=%0d exp>=2", low_run);
                    end
                end
                low_run = o_tx_enable ? 0 : low_run + 1;
                if (i_tx_busy) begin
                    checks++;
                    if (o_data_tx !== cur_tx) begin
                        failures++;
                        $display("FAIL tx_stable got=%h exp=%h", o_data_tx, cur_tx);
                    end
                end
                if (o_rx_valid) begin
                    rx_cnt++;
                    checks++;
                    if (exp_rx.size() == 0) begin
                        failures++;
                        $display("FAIL rx_unexpected data=%h", o_rx_data);
                    end else begin
                        e = exp_rx.pop_front();
                        if (o_rx_data !== e) begin
                            failures++;
                            $display("FAIL rx_data got=%h exp=%h", o_rx_data, e);
                        end
                    end
                end
                if (o_timeout_err) tmo_cnt++;
                if (o_rx_valid || o_timeout_err) begin
                    checks++;
                    if (o_rx_valid && o_timeout_err) begin
                        failures++;
                        $display("FAIL strobe_exclusive got=both exp=one");
                    end
                end
                en_prev_mon = o_tx_enable;
            end else begin
                en_prev_mon = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] d);
        i_wr_valid = 1'b1;
        i_wr_data  = d;
        exp_tx.push_back(d);
        step();
        i_wr_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max, input string nm);
        int n;
        n = 0;
        while (!o_idle && n < max) begin
            step();
            n++;
        end
        checks++;
        if (o_idle !== 1'b1) begin
            failures++;
            $display("FAIL %s_idle_timeout got=%b exp=1", nm, o_idle);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++;
        if ({o_tx_enable, o_data_tx, o_rx_valid, o_rx_data, o_timeout_err}
            !== 19'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%b%h%b%h%b exp=0", o_tx_enable,
                     o_data_tx, o_rx_valid, o_rx_data, o_timeout_err);
        end
        checks++;
        if ({o_fifo_level, o_wr_ready, o_idle} !== {4'd0, 2'b11}) begin
            failures++;
            $display("FAIL reset_fifo got=%0d/%b/%b exp=0/1/1",
                     o_fifo_level, o_wr_ready, o_idle);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        int rx0;
        rx0 = rx_cnt;
        push_byte(8'hA5);
        checks++;
        if (o_fifo_level !== 4'd1 || o_tx_enable !== 1'b0) begin
            failures++;
            $display("FAIL single_e0 got=%0d/%b exp=1/0", o_fifo_level, o_tx_enable);
        end
        step();
        checks++;
        if (o_fifo_level !== 4'd0 || o_tx_enable !== 1'b0) begin
            failures++;
            $display("FAIL single_e1 got=%0d/%b exp=0/0", o_fifo_level, o_tx_enable);
        end
        step();
        checks++;
        if (o_tx_enable !== 1'b1 || o_data_tx !== 8'hA5) begin
            failures++;
            $display("FAIL single_e2 got=%b/%h exp=1/a5", o_tx_enable, o_data_tx);
        end
        wait_idle(100, "single");
        checks++;
        if (rx_cnt - rx0 !== 1 || o_rx_data !== 8'h3C || o_data_tx !== 8'hA5) begin
            failures++;
            $display("FAIL single_done got=%0d/%h/%h exp=1/3c/a5",
                     rx_cnt - rx0, o_rx_data, o_data_tx);
        end
    endtask

    task automatic test_burst();
        int rx0;
        rx0 = rx_cnt;
        for (int i = 1; i <= 10; i++) begin
            i_wr_valid = 1'b1;
            i_wr_data  = 8'(i);
            // byte 1 is popped on the next edge, so byte 10 finds the FIFO full
            if (i <= 9) exp_tx.push_back(8'(i));
            step();
            if (i == 9) begin
                checks++;
                if (o_fifo_level !== 4'd8 || o_wr_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL burst_full got=%0d/%b exp=8/0",
                             o_fifo_level, o_wr_ready);
                end
            end
        end
        i_wr_valid = 1'b0;
        checks++;
        if (o_fifo_level !== 4'd8) begin
            failures++;
            $display("FAIL burst_ignored got=%0d exp=8", o_fifo_level);
        end
        wait_idle(1000, "burst");
        checks++;
        if (rx_cnt - rx0 !== 9 || o_fifo_level !== 4'd0 || o_wr_ready !== 1'b1) begin
            failures++;
            $display("FAIL burst_done got=%0d/%0d/%b exp=9/0/1",
                     rx_cnt - rx0, o_fifo_level, o_wr_ready);
        end
    endtask

    task automatic test_timeout();
        int n;
        int m;
        int rx0;
        int t0;
        rx0 = rx_cnt;
        t0 = tmo_cnt;
        master_never = 1'b1;
        push_byte(8'h55);
        push_byte(8'h66);
        n = 0;
        while (!o_tx_enable && n < 50) begin
            step();
            n++;
        end
        m = 0;
        while (!o_timeout_err && m < 50) begin
            step();
            m++;
        end
        master_never = 1'b0;
        // enable rises one cycle into LAUNCH, timeout after LAUNCH_TIMEOUT cycles
        checks++;
        if (m !== LAUNCH_TIMEOUT - 1 || o_tx_enable !== 1'b0) begin
            failures++;
            $display("FAIL timeout_latency got=%0d/%b exp=%0d/0",
                     m, o_tx_enable, LAUNCH_TIMEOUT - 1);
        end
        wait_idle(200, "timeout");
        checks++;
        if (tmo_cnt - t0 !== 1 || rx_cnt - rx0 !== 1) begin
            failures++;
            $display("FAIL timeout_counts got=%0d/%0d exp=1/1",
                     tmo_cnt - t0, rx_cnt - rx0);
        end
    endtask

    task automatic test_back_to_back();
        int r0;
        int rx0;
        r0 = rise_cnt;
        rx0 = rx_cnt;
        push_byte(8'h11);
        push_byte(8'h22);
        wait_idle(200, "b2b");
        checks++;
        if (rise_cnt - r0 !== 2 || rx_cnt - rx0 !== 2) begin
            failures++;
            $display("FAIL b2b_counts got=%0d/%0d exp=2/2",
                     rise_cnt - r0, rx_cnt - rx0);
        end
    endtask

    task automatic test_push_during_pop();
        int rx0;
        rx0 = rx_cnt;
        push_byte(8'h44);
        checks++;
        if (o_fifo_level !== 4'd1) begin
            failures++;
            $display("FAIL pushpop_pre got=%0d exp=1", o_fifo_level);
        end
        push_byte(8'h45);
        checks++;
        if (o_fifo_level !== 4'd1) begin
            failures++;
            $display("FAIL pushpop_level got=%0d exp=1", o_fifo_level);
        end
        wait_idle(200, "pushpop");
        checks++;
        if (rx_cnt - rx0 !== 2) begin
            failures++;
            $display("FAIL pushpop_rx got=%0d exp=2", rx_cnt - rx0);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        int rx0;
        int r0;
        push_byte(8'h31);
        push_byte(8'h32);
        push_byte(8'h33);
        push_byte(8'h34);
        n = 0;
        while (!i_tx_busy && n < 50) begin
            step();
            n++;
        end
        checks++;
        if (i_tx_busy !== 1'b1 || o_fifo_level !== 4'd3) begin
            failures++;
            $display("FAIL rstmid_pre got=%b/%0d exp=1/3", i_tx_busy, o_fifo_level);
        end
        abort_req = 1'b1;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        exp_tx.delete();
        checks++;
        if ({o_tx_enable, o_fifo_level, o_idle, o_rx_valid, o_wr_ready}
            !== {1'b0, 4'd0, 1'b1, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL rstmid_after got=%b/%0d/%b/%b/%b exp=0/0/1/0/1",
                     o_tx_enable, o_fifo_level, o_idle, o_rx_valid, o_wr_ready);
        end
        rx0 = rx_cnt;
        r0 = rise_cnt;
        repeat (20) step();
        checks++;
        if (rx_cnt !== rx0 || rise_cnt !== r0) begin
            failures++;
            $display("FAIL rstmid_quiet got=%0d/%0d exp=0/0",
                     rx_cnt - rx0, rise_cnt - r0);
        end
        push_byte(8'h77);
        wait_idle(200, "rstmid");
        checks++;
        if (rx_cnt - rx0 !== 1) begin
            failures++;
            $display("FAIL rstmid_new got=%0d exp=1", rx_cnt - rx0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        i_wr_valid = 1'b0;
        i_wr_data  = 8'h00;
        i_tx_busy  = 1'b0;
        i_data_rx  = 8'h00;
        step();
        test_reset();
        test_single();
        test_burst();
        test_timeout();
        test_back_to_back();
        test_push_during_pop();
        test_reset_mid();
        checks++;
        if (exp_tx.size() != 0 || exp_rx.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_left got=%0d/%0d exp=0/0",
                     exp_tx.size(), exp_rx.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
